ip_sdram_ctrl: RTL and testbench
================================

// Module: ip_sdram_ctrl
// PURPOSE
//  RAM-side responder for the 22-bit byte-addressed RAM I/F (rd/wr/busy/address/wdata/rdata/rdata_en) driven by the
//  memory-mapper and cartridge blocks. Runs the init sequence and periodic auto-refresh, and converts each byte request
//  into a single ACTIVE + READA/WRITEA access on an external x16 SDRAM (4 banks, 11-bit row, 8-bit column).
//  Sits between the bus-side IP blocks and the SDRAM pins. One request is in flight at a time.
// PARAMETERS
//  T_INIT   14'd10800  NOP cycles after reset before PRECHARGE ALL (>=200us at clk)
//  T_REFI   10'd400    cycles between auto-refresh requests
//  T_RP     3'd2       PRECHARGE/auto-precharge to next command, cycles
//  T_RCD    3'd2       ACTIVE to READA/WRITEA, cycles
//  T_RFC    4'd7       AUTO REFRESH to next command, cycles
//  T_WR     3'd2       WRITEA data to start of auto-precharge, cycles
//  CL       3'd2       CAS latency (2 or 3); also written into the mode register
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  reset        in   1   synchronous, active-high reset
//  rd           in   1   read request level from requester
//  wr           in   1   write request level from requester
//  busy         out  1   1 = cannot accept a new request
//  address      in   22  byte address; [21:20]=bank, [19:9]=row, [8:1]=column, [0]=byte lane
//  wdata        in   8   write byte
//  rdata        out  8   read byte; held until next read completes
//  rdata_en     out  1   one-cycle strobe, rdata valid
//  sdram_cke    out  1   clock enable
//  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
//  sdram_ba     out  2   bank address
//  sdram_a      out  11  row/column/mode address
//  sdram_dqm    out  2   byte masks, active high (bit0 = DQ[7:0])
//  sdram_dq_o   out  16  write data
//  sdram_dq_oe  out  1   1 = drive DQ
//  sdram_dq_i   in   16  read data from pins
// BEHAVIOUR
//  Reset values: cke=0, cs_n=ras_n=cas_n=we_n=1, ba=0, a=0, dqm=2'b11, dq_o=0, dq_oe=0, busy=1, rdata=0, rdata_en=0.
//  All SDRAM outputs registered. NOP = cs_n 0, ras/cas/we 1. Every non-command cycle is NOP (cs_n=1 only during reset).
//  States: INIT_WAIT -> INIT_PRE -> INIT_REF(x8) -> INIT_MRS -> IDLE; IDLE -> REFRESH | ACT; ACT -> RD | WR (after T_RCD);
//    RD -> RD_WAIT (CL+1) -> IDLE; WR -> WR_WAIT (T_WR+T_RP) -> IDLE; REFRESH -> wait T_RFC -> IDLE.
//  Init: cke=1 from the first cycle after reset. T_INIT NOPs. PRECHARGE ALL (a[10]=1), wait T_RP. Eight AUTO REFRESH
//    commands, each followed by T_RFC wait. MRS with a=11'h0?0: BL=1, sequential, a[6:4]=CL, a[9]=0. Wait 2 cycles, then IDLE.
//  Request detect: req edge = (rd|wr) high now and low the previous cycle. Edge latches address, wdata and type into a
//    one-entry pending slot if the slot is empty; edges while the slot is full are ignored.
//    Held levels never re-trigger. rd and wr on the same edge -> write.
//  busy = (state != IDLE) | pending | refresh_due. The requester issues a new edge only when busy=0.
//  Refresh: counter starts at INIT_MRS exit and sets refresh_due every T_REFI cycles. In IDLE, refresh_due beats pending.
//    AUTO REFRESH clears refresh_due. The counter never stops, so a due flag set during an access is served at next IDLE.
//  Access: ACTIVE (ba, a=row). After T_RCD, issue READA/WRITEA: a[10]=1 (auto-precharge), a[7:0]=column.
//  Write: dq_oe=1 and dq_o={wdata,wdata} for the WRITEA cycle only. dqm = address[0] ? 2'b01 : 2'b10.
//  Read: dqm=2'b00. dq_i is sampled CL cycles after the READA cycle. rdata = address[0] ? dq_i[15:8] : dq_i[7:0].
//    rdata_en is high for 1 cycle.
//  Latency, edge at cycle E in IDLE with no refresh due: ACTIVE on pins at E+1, READA/WRITEA at E+1+T_RCD,
//    rdata_en at E+2+T_RCD+CL (E+6 with defaults). busy falls when IDLE is re-entered: read E+2+T_RCD+CL, write E+2+T_RCD+T_WR+T_RP.
//  Reset mid-operation: abort on the next edge. Return to INIT_WAIT with reset values. Pending slot and refresh_due cleared,
//    no rdata_en produced. Full init sequence repeats.
// TESTING
//  1 Reset, then run with the SDRAM model -> cke=1 at cycle 1. PRE-ALL after T_INIT NOPs, 8 REF, MRS a=11'h020 (CL=2).
//    busy stays 1 until IDLE, then 0.
//  2 Write 8'hA5 @22'h12_3457, then read the same address -> ACT ba=1 row=11'h11A, WRITEA col=8'h2B dqm=2'b01.
//    Read returns rdata=8'hA5 with rdata_en exactly at E+6.
//  3 Write 8'h3C @even address and 8'hC3 @odd neighbour, then read both -> 8'h3C then 8'hC3.
//    Read dqm=2'b00, each byte selected by address[0].
//  4 Hold rd high 40 cycles -> exactly one ACT/READA and one rdata_en. Assert rd and wr together -> WRITEA issued.
//  5 Force refresh_due on the same cycle as a read edge -> REF first, then ACT after T_RFC.
//    Data is correct and busy stays 1 throughout.
//  6 Assert reset 1 cycle after READA -> no rdata_en, outputs at reset values next cycle, and the init sequence restarts.

Source files
------------

// File: rtl/ip_sdram_ctrl_if.sv
// rtl/ip_sdram_ctrl_if.sv - byte-addressed RAM request/response bus between requesters and the SDRAM controller
interface ip_sdram_ctrl_if;
    logic        rd;
    logic        wr;
    logic        busy;
    logic [21:0] address;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rdata_en;

    modport master (
        output rd, wr, address, wdata,
        input  busy, rdata, rdata_en
    );

    modport slave (
        input  rd, wr, address, wdata,
        output busy, rdata, rdata_en
    );
endinterface

// File: rtl/ip_sdram_ctrl.sv
// rtl/ip_sdram_ctrl.sv - byte-request to x16 SDRAM controller with init sequence and periodic auto-refresh
module ip_sdram_ctrl #(
    parameter logic [13:0] T_INIT = 14'd10800,
    parameter logic [9:0]  T_REFI = 10'd400,
    parameter logic [2:0]  T_RP   = 3'd2,
    parameter logic [2:0]  T_RCD  = 3'd2,
    parameter logic [3:0]  T_RFC  = 4'd7,
    parameter logic [2:0]  T_WR   = 3'd2,
    parameter logic [2:0]  CL     = 3'd2
) (
    input  logic           clk,
    input  logic           reset,
    ip_sdram_ctrl_if.slave bus,
    output logic           sdram_cke,
    output logic           sdram_cs_n,
    output logic           sdram_ras_n,
    output logic           sdram_cas_n,
    output logic           sdram_we_n,
    output logic [1:0]     sdram_ba,
    output logic [10:0]    sdram_a,
    output logic [1:0]     sdram_dqm,
    output logic [15:0]    sdram_dq_o,
    output logic           sdram_dq_oe,
    input  logic [15:0]    sdram_dq_i
);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INH = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    // Counter reloads are "cycles until next command" minus one; the IDLE hop after refresh costs one more.
    localparam logic [13:0] C_RP       = {11'd0, T_RP} - 14'd1;
    localparam logic [13:0] C_RCD      = {11'd0, T_RCD} - 14'd1;
    localparam logic [13:0] C_RFC_INIT = {10'd0, T_RFC} - 14'd1;
    localparam logic [13:0] C_RFC_IDLE = {10'd0, T_RFC} - 14'd2;
    localparam logic [13:0] C_CL       = {11'd0, CL} - 14'd1;
    localparam logic [13:0] C_WRP      = {11'd0, T_WR} + {11'd0, T_RP} - 14'd1;

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF, S_INIT_MRS, S_IDLE,
        S_REFRESH, S_ACT, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT
    } state_t;

    state_t      r_state, w_state_n;
    logic [13:0] r_cnt, w_cnt_n;
    logic [2:0]  r_ref_cnt, w_ref_cnt_n;
    logic [3:0]  r_cmd, w_cmd_n;
    logic [1:0]  r_ba, w_ba_n;
    logic [10:0] r_a, w_a_n;
    logic [1:0]  r_dqm, w_dqm_n;
    logic [15:0] r_dq_o, w_dq_o_n;
    logic        r_dq_oe, w_dq_oe_n;
    logic        r_cke;
    logic [7:0]  r_rdata;
    logic        r_rdata_en;

    logic        r_req_q, r_pend, r_pend_wr;
    logic [21:0] r_pend_addr;
    logic [7:0]  r_pend_wdata;
    logic        r_cur_wr, r_cur_lane;
    logic [1:0]  r_cur_ba;
    logic [7:0]  r_cur_col, r_cur_wdata;
    logic        r_refi_en, r_refresh_due;
    logic [9:0]  r_refi_cnt;

    logic        w_edge, w_req_wr, w_take, w_ref_clr, w_refi_start, w_capture, w_refi_hit;
    logic [21:0] w_req_addr;
    logic [7:0]  w_req_wdata;

    assign w_edge      = (bus.rd | bus.wr) & ~r_req_q;
    assign w_req_wr    = r_pend ? r_pend_wr    : bus.wr;
    assign w_req_addr  = r_pend ? r_pend_addr  : bus.address;
    assign w_req_wdata = r_pend ? r_pend_wdata : bus.wdata;
    assign w_refi_hit  = r_refi_en && (r_refi_cnt == T_REFI - 10'd1);

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = (r_cnt == 14'd0) ? 14'd0 : r_cnt - 14'd1;
        w_ref_cnt_n  = r_ref_cnt;
        w_cmd_n      = CMD_NOP;
        w_ba_n       = r_ba;
        w_a_n        = r_a;
        w_dqm_n      = 2'b11;
        w_dq_o_n     = r_dq_o;
        w_dq_oe_n    = 1'b0;
        w_take       = 1'b0;
        w_ref_clr    = 1'b0;
        w_refi_start = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_INIT_WAIT: if (r_cnt == 14'd0) begin
                w_cmd_n   = CMD_PRE;
                w_a_n     = 11'h400;
                w_state_n = S_INIT_PRE;
                w_cnt_n   = C_RP;
            end
            S_INIT_PRE: if (r_cnt == 14'd0) begin
                w_cmd_n     = CMD_REF;
                w_state_n   = S_INIT_REF;
                w_cnt_n     = C_RFC_INIT;
                w_ref_cnt_n = 3'd0;
            end
            S_INIT_REF: if (r_cnt == 14'd0) begin
                if (r_ref_cnt == 3'd7) begin
                    // Burst length 1, sequential, CAS latency in a[6:4].
                    w_cmd_n   = CMD_MRS;
                    w_ba_n    = 2'b00;
                    w_a_n     = {4'b0000, CL, 4'b0000};
                    w_state_n = S_INIT_MRS;
                    w_cnt_n   = 14'd1;
                end else begin
                    w_cmd_n     = CMD_REF;
                    w_cnt_n     = C_RFC_INIT;
                    w_ref_cnt_n = r_ref_cnt + 3'd1;
                end
            end
            S_INIT_MRS: if (r_cnt == 14'd0) begin
                w_state_n    = S_IDLE;
                w_refi_start = 1'b1;
            end
            S_IDLE: begin
                if (r_refresh_due) begin
                    w_cmd_n   = CMD_REF;
                    w_state_n = S_REFRESH;
                    w_cnt_n   = C_RFC_IDLE;
                    w_ref_clr = 1'b1;
                end else if (r_pend || w_edge) begin
                    w_take    = 1'b1;
                    w_cmd_n   = CMD_ACT;
                    w_ba_n    = w_req_addr[21:20];
                    w_a_n     = w_req_addr[19:9];
                    w_state_n = S_ACT;
                    w_cnt_n   = C_RCD;
                end
            end
            S_REFRESH: if (r_cnt == 14'd0) w_state_n = S_IDLE;
            S_ACT: if (r_cnt == 14'd0) begin
                w_ba_n = r_cur_ba;
                w_a_n  = {1'b1, 2'b00, r_cur_col};
                if (r_cur_wr) begin
                    w_cmd_n   = CMD_WR;
                    w_state_n = S_WR;
                    w_dq_oe_n = 1'b1;
                    w_dq_o_n  = {r_cur_wdata, r_cur_wdata};
                    w_dqm_n   = r_cur_lane ? 2'b01 : 2'b10;
                end else begin
                    w_cmd_n   = CMD_RD;
                    w_state_n = S_RD;
                    w_dqm_n   = 2'b00;
                end
            end
            S_RD: begin
                w_dqm_n   = 2'b00;
                w_state_n = S_RD_WAIT;
                w_cnt_n   = C_CL;
            end
            S_RD_WAIT: begin
                w_dqm_n = 2'b00;
                if (r_cnt == 14'd0) begin
                    w_capture = 1'b1;
                    w_state_n = S_IDLE;
                end
            end
            S_WR: begin
                w_state_n = S_WR_WAIT;
                w_cnt_n   = C_WRP;
            end
            S_WR_WAIT: if (r_cnt == 14'd0) w_state_n = S_IDLE;
            default: w_state_n = S_INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_INIT_WAIT;
            r_cnt      <= T_INIT;
            r_ref_cnt  <= 3'd0;
            r_cke      <= 1'b0;
            r_cmd      <= CMD_INH;
            r_ba       <= 2'b00;
            r_a        <= 11'd0;
            r_dqm      <= 2'b11;
            r_dq_o     <= 16'd0;
            r_dq_oe    <= 1'b0;
            r_rdata    <= 8'd0;
            r_rdata_en <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_ref_cnt  <= w_ref_cnt_n;
            r_cke      <= 1'b1;
            r_cmd      <= w_cmd_n;
            r_ba       <= w_ba_n;
            r_a        <= w_a_n;
            r_dqm      <= w_dqm_n;
            r_dq_o     <= w_dq_o_n;
            r_dq_oe    <= w_dq_oe_n;
            r_rdata_en <= w_capture;
            if (w_capture) r_rdata <= r_cur_lane ? sdram_dq_i[15:8] : sdram_dq_i[7:0];
        end
    end

    // One-entry pending slot plus the request currently being served.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_q       <= 1'b0;
            r_pend        <= 1'b0;
            r_pend_wr     <= 1'b0;
            r_pend_addr   <= 22'd0;
            r_pend_wdata  <= 8'd0;
            r_cur_wr      <= 1'b0;
            r_cur_lane    <= 1'b0;
            r_cur_ba      <= 2'b00;
            r_cur_col     <= 8'd0;
            r_cur_wdata   <= 8'd0;
            r_refi_en     <= 1'b0;
            r_refi_cnt    <= 10'd0;
            r_refresh_due <= 1'b0;
        end else begin
            r_req_q <= bus.rd | bus.wr;
            if (w_take) begin
                r_cur_wr    <= w_req_wr;
                r_cur_lane  <= w_req_addr[0];
                r_cur_ba    <= w_req_addr[21:20];
                r_cur_col   <= w_req_addr[8:1];
                r_cur_wdata <= w_req_wdata;
                r_pend      <= 1'b0;
            end else if (w_edge && !r_pend) begin
                r_pend       <= 1'b1;
                r_pend_wr    <= bus.wr;
                r_pend_addr  <= bus.address;
                r_pend_wdata <= bus.wdata;
            end
            if (w_refi_start) begin
                r_refi_en  <= 1'b1;
                r_refi_cnt <= 10'd0;
            end else if (w_refi_hit) begin
                r_refi_cnt <= 10'd0;
            end else if (r_refi_en) begin
                r_refi_cnt <= r_refi_cnt + 10'd1;
            end
            r_refresh_due <= w_refi_hit | (r_refresh_due & ~w_ref_clr);
        end
    end

    assign bus.busy    = (r_state != S_IDLE) | r_pend | r_refresh_due;
    assign bus.rdata   = r_rdata;
    assign bus.rdata_en = r_rdata_en;

    assign sdram_cke   = r_cke;
    assign sdram_cs_n  = r_cmd[3];
    assign sdram_ras_n = r_cmd[2];
    assign sdram_cas_n = r_cmd[1];
    assign sdram_we_n  = r_cmd[0];
    assign sdram_ba    = r_ba;
    assign sdram_a     = r_a;
    assign sdram_dqm   = r_dqm;
    assign sdram_dq_o  = r_dq_o;
    assign sdram_dq_oe = r_dq_oe;

endmodule

// File: tb/tb_ip_sdram_ctrl.sv
// tb/tb_ip_sdram_ctrl.sv - directed self-checking bench for ip_sdram_ctrl with a behavioural SDRAM model
module tb_ip_sdram_ctrl;
    localparam int CL_CYC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_dq_oe;
    logic [1:0]  sdram_ba, sdram_dqm;
    logic [10:0] sdram_a;
    logic [15:0] sdram_dq_o;
    logic [15:0] sdram_dq_i = 16'hDEAD;

    ip_sdram_ctrl_if bus ();

    ip_sdram_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .sdram_cke   (sdram_cke),
        .sdram_cs_n  (sdram_cs_n),
        .sdram_ras_n (sdram_ras_n),
        .sdram_cas_n (sdram_cas_n),
        .sdram_we_n  (sdram_we_n),
        .sdram_ba    (sdram_ba),
        .sdram_a     (sdram_a),
        .sdram_dqm   (sdram_dqm),
        .sdram_dq_o  (sdram_dq_o),
        .sdram_dq_oe (sdram_dq_oe),
        .sdram_dq_i  (sdram_dq_i)
    );

    always #5 clk = ~clk;

    // SDRAM model and command log; cycle c is processed at the posedge that ends it.
    int          cyc = 0;
    logic [15:0] mem [int];
    logic [10:0] row_of [4];
    int n_act = 0, n_rda = 0, n_wra = 0, n_ref = 0, n_pre = 0, n_mrs = 0, n_rden = 0, n_oe = 0;
    int act_cyc = -1, rda_cyc = -1, wra_cyc = -1, rden_cyc = -1, mrs_cyc = -1, ref_cyc = -1;
    int busy_fall_cyc = -1, first_cke_cyc = -1, nop_cnt = 0, rd_at = -1, key = 0;
    logic [1:0]  act_ba = 0, wr_dqm = 0, rd_dqm = 0;
    logic [10:0] act_row = 0, mrs_a = 0, pre_a = 0;
    logic [7:0]  wr_col = 0, rden_data = 0;
    logic [15:0] wr_dq = 0, rd_word = 0, w_tmp = 0;
    logic        wr_oe = 0, pre_seen = 0, prev_busy = 1;
    logic [3:0]  cmd;

    always @(posedge clk) begin
        if (rd_at == cyc + 1) sdram_dq_i <= rd_word;
        else                  sdram_dq_i <= 16'hDEAD;
        cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
        if (reset) begin
            pre_seen      = 1'b0;
            nop_cnt       = 0;
            first_cke_cyc = -1;
        end else begin
            if (sdram_cke && first_cke_cyc < 0) first_cke_cyc = cyc;
            if (sdram_cke && !pre_seen && cmd == 4'b0111) nop_cnt++;
            key = {11'd0, sdram_ba, row_of[sdram_ba], sdram_a[7:0]};
            case (cmd)
                4'b0011: begin
                    n_act++; act_cyc = cyc; act_ba = sdram_ba; act_row = sdram_a;
                    row_of[sdram_ba] = sdram_a;
                end
                4'b0101: begin
                    n_rda++; rda_cyc = cyc; rd_dqm = sdram_dqm;
                    rd_word = mem.exists(key) ? mem[key] : 16'h0000;
                    rd_at = cyc + CL_CYC;
                end
                4'b0100: begin
                    n_wra++; wra_cyc = cyc; wr_col = sdram_a[7:0]; wr_dqm = sdram_dqm;
                    wr_dq = sdram_dq_o; wr_oe = sdram_dq_oe;
                    w_tmp = mem.exists(key) ? mem[key] : 16'h0000;
                    if (!sdram_dqm[0]) w_tmp[7:0]  = sdram_dq_o[7:0];
                    if (!sdram_dqm[1]) w_tmp[15:8] = sdram_dq_o[15:8];
                    mem[key] = w_tmp;
                end
                4'b0010: begin n_pre++; pre_a = sdram_a; pre_seen = 1'b1; end
                4'b0001: begin n_ref++; ref_cyc = cyc; end
                4'b0000: begin n_mrs++; mrs_a = sdram_a; mrs_cyc = cyc; end
                default: ;
            endcase
            if (sdram_dq_oe) n_oe++;
        end
        if (bus.rdata_en) begin n_rden++; rden_cyc = cyc; rden_data = bus.rdata; end
        if (prev_busy && !bus.busy) busy_fall_cyc = cyc;
        prev_busy = bus.busy;
        cyc++;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (bus.busy !== 1'b0 && k < limit) begin @(negedge clk); k++; end
        if (bus.busy !== 1'b0) check("idle_timeout", bus.busy, 0);
    endtask

    task automatic wait_init(input int mrs0);
        int k = 0;
        while (n_mrs == mrs0 && k < 12000) begin @(negedge clk); k++; end
        if (n_mrs == mrs0) check("init_timeout", n_mrs, mrs0 + 1);
    endtask

    task automatic sync_refresh();
        int n0 = n_ref;
        int k = 0;
        while (n_ref == n0 && k < 600) begin @(negedge clk); k++; end
        if (n_ref == n0) check("refresh_timeout", n_ref, n0 + 1);
        wait_idle(50);
    endtask

    task automatic issue(input logic r, input logic w, input logic [21:0] addr, input logic [7:0] d, output int e);
        wait_idle(2000);
        bus.rd = r; bus.wr = w; bus.address = addr; bus.wdata = d;
        e = cyc;
        @(negedge clk);
        bus.rd = 1'b0; bus.wr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, t0, k, n0, n1, n2, n3, zeros;
        reset = 1'b1;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.address = 22'd0; bus.wdata = 8'd0;
        repeat (3) @(negedge clk);

        // 1: reset values and init sequence
        check("rst_cke", sdram_cke, 0);
        check("rst_cmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 4'b1111);
        check("rst_dqm", sdram_dqm, 2'b11);
        check("rst_a", {sdram_ba, sdram_a}, 0);
        check("rst_oe", {sdram_dq_oe, sdram_dq_o}, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_rdata", {bus.rdata_en, bus.rdata}, 0);
        reset = 1'b0;
        t0 = cyc;
        wait_init(0);
        check("cke_first", first_cke_cyc, t0 + 1);
        check("init_nops", nop_cnt, 10800);
        check("pre_a10", pre_a[10], 1);
        check("init_refs", n_ref, 8);
        check("mrs_a", mrs_a, 11'h020);
        check("busy_in_mrs", bus.busy, 1);
        wait_idle(100);
        @(negedge clk);
        check("idle_entry", busy_fall_cyc, mrs_cyc + 2);

        // 2: write then read 22'h12_3457
        sync_refresh();
        n0 = n_oe;
        issue(1'b0, 1'b1, 22'h123457, 8'hA5, e);
        repeat (6) @(negedge clk);
        check("wr_act_ba", act_ba, 2'd1);
        check("wr_act_row", act_row, 11'h11A);
        check("wr_act_cyc", act_cyc, e + 1);
        check("wr_cyc", wra_cyc, e + 3);
        check("wr_col", wr_col, 8'h2B);
        check("wr_dqm", wr_dqm, 2'b01);
        check("wr_dq", {wr_oe, wr_dq}, {1'b1, 16'hA5A5});
        check("wr_oe_len", n_oe - n0, 1);
        wait_idle(50);
        @(negedge clk);
        check("wr_busy_fall", busy_fall_cyc, e + 8);
        n1 = n_rden;
        issue(1'b1, 1'b0, 22'h123457, 8'h00, e);
        repeat (7) @(negedge clk);
        check("rd_cyc", rda_cyc, e + 3);
        check("rd_dqm", rd_dqm, 2'b00);
        check("rd_en_cyc", rden_cyc, e + 6);
        check("rd_data", rden_data, 8'hA5);
        check("rd_en_cnt", n_rden - n1, 1);
        check("rd_busy_fall", busy_fall_cyc, e + 6);

        // 3: byte lanes of one word
        sync_refresh();
        issue(1'b0, 1'b1, 22'h0A2468, 8'h3C, e);
        repeat (4) @(negedge clk);
        check("even_wr_dqm", wr_dqm, 2'b10);
        issue(1'b0, 1'b1, 22'h0A2469, 8'hC3, e);
        issue(1'b1, 1'b0, 22'h0A2468, 8'h00, e);
        repeat (7) @(negedge clk);
        check("even_rd_data", rden_data, 8'h3C);
        check("even_rd_dqm", rd_dqm, 2'b00);
        issue(1'b1, 1'b0, 22'h0A2469, 8'h00, e);
        repeat (7) @(negedge clk);
        check("odd_rd_data", rden_data, 8'hC3);

        // 4: held level and simultaneous rd/wr
        sync_refresh();
        n0 = n_act; n1 = n_rda; n2 = n_rden;
        bus.address = 22'h0A2469;
        bus.rd = 1'b1;
        repeat (40) @(negedge clk);
        bus.rd = 1'b0;
        wait_idle(50);
        @(negedge clk);
        check("hold_act", n_act - n0, 1);
        check("hold_rda", n_rda - n1, 1);
        check("hold_rden", n_rden - n2, 1);
        check("hold_data", rden_data, 8'hC3);
        n1 = n_rda; n3 = n_wra;
        issue(1'b1, 1'b1, 22'h0A2468, 8'h5A, e);
        wait_idle(50);
        @(negedge clk);
        check("rdwr_wra", n_wra - n3, 1);
        check("rdwr_rda", n_rda - n1, 0);
        issue(1'b1, 1'b0, 22'h0A2468, 8'h00, e);
        repeat (7) @(negedge clk);
        check("rdwr_data", rden_data, 8'h5A);

        // 5: read edge on the cycle refresh becomes due
        wait_idle(600);
        k = 0;
        while (bus.busy !== 1'b1 && k < 600) begin @(negedge clk); k++; end
        if (bus.busy !== 1'b1) check("due_timeout", bus.busy, 1);
        repeat (400) @(negedge clk);
        check("due_busy", bus.busy, 1);
        bus.rd = 1'b1; bus.address = 22'h123457;
        e = cyc;
        zeros = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            bus.rd = 1'b0;
            if (bus.busy !== 1'b1) zeros++;
        end
        @(negedge clk);
        @(negedge clk);
        check("coll_busy_low", zeros, 0);
        check("coll_ref_cyc", ref_cyc, e + 1);
        check("coll_act_cyc", act_cyc, e + 8);
        check("coll_rden_cyc", rden_cyc, e + 13);
        check("coll_data", rden_data, 8'hA5);

        // 6: reset one cycle after READA
        sync_refresh();
        n0 = n_rden; n1 = n_ref; n2 = n_mrs;
        issue(1'b1, 1'b0, 22'h123457, 8'h00, e);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_rda_cyc", rda_cyc, e + 3);
        check("abort_cke", sdram_cke, 0);
        check("abort_cmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 4'b1111);
        check("abort_dqm", sdram_dqm, 2'b11);
        check("abort_busy", bus.busy, 1);
        check("abort_rdata", {bus.rdata_en, bus.rdata}, 0);
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        repeat (20) @(negedge clk);
        check("abort_no_rden", n_rden - n0, 0);
        wait_init(n2);
        check("reinit_cke", first_cke_cyc, t0 + 1);
        check("reinit_nops", nop_cnt, 10800);
        check("reinit_refs", n_ref - n1, 8);
        check("reinit_mrs", mrs_a, 11'h020);
        issue(1'b1, 1'b0, 22'h123457, 8'h00, e);
        repeat (7) @(negedge clk);
        check("reinit_rd", rden_data, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
